dmem_ctrl: RTL and testbench

Load/store unit between the single-cycle datapath and the byte-wide data memory (8-bit address, one byte per access).
- Accepts one byte, half-word or word request, serialises it into sequential byte accesses in big-endian (MIPS) order, and assembles or sign-extends read data.
- Holds the datapath off with busy while a transfer is in progress.
- Replaces the direct processor-to-dmemory hookup; the datapath drives req/we/size from the load/store decode and the ALU address.

---
 rtl/dmem_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Load/store unit: serialises byte/half/word requests into big-endian byte
// accesses on a byte-wide synchronous memory and assembles or extends load data.
module dmem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        fsm_state
);

  // Handshake: req is taken on any edge where the unit is IDLE or DONE; busy is
  // high for the whole transfer, then exactly one of done/err pulses for one cycle.
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [1:0]  last;
  logic        lat_we;
  logic        lat_sext;
  logic [1:0]  lat_size;
  logic [31:0] wshift;
  logic [23:0] rshift;
  logic        rd_pend;

  logic        accept;
  logic        misaligned;
  logic [31:0] wd_aligned;
  logic [31:0] rfinal;
  logic [31:0] rext;

  assign fsm_state  = state;
  assign accept     = req && (state == IDLE || state == DONE);
  assign misaligned = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);
  assign rfinal     = {rshift, mem_rdata};

  // Left-justify store data so byte k is always the top byte after k shifts.
  always_comb begin
    wd_aligned = wdata;
    case (size)
      2'b00:   wd_aligned = {wdata[7:0], 24'h0};
      2'b01:   wd_aligned = {wdata[15:0], 16'h0};
      default: wd_aligned = wdata;
    endcase
  end

  always_comb begin
    rext = rfinal;
    case (lat_size)
      2'b00:   rext = lat_sext ? {{24{rfinal[7]}}, rfinal[7:0]} : {24'h0, rfinal[7:0]};
      2'b01:   rext = lat_sext ? {{16{rfinal[15]}}, rfinal[15:0]} : {16'h0, rfinal[15:0]};
      default: rext = rfinal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= 2'd0;
      last      <= 2'd0;
      lat_we    <= 1'b0;
      lat_sext  <= 1'b0;
      lat_size  <= 2'b00;
      wshift    <= 32'h0;
      rshift    <= 24'h0;
      rd_pend   <= 1'b0;
      rdata     <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      // Memory data lags the read strobe by one cycle.
      rd_pend <= mem_re;
      if (rd_pend) rshift <= rfinal[23:0];

      case (state)
        IDLE, DONE: begin
          if (accept && misaligned) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (accept) begin
            state    <= XFER;
            busy     <= 1'b1;
            beat     <= 2'd0;
            last     <= (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
            lat_we   <= we;
            lat_size <= size;
            lat_sext <= sign_ext;
            mem_addr <= addr;
            if (we) begin
              mem_we    <= 1'b1;
              mem_wdata <= wd_aligned[31:24];
              wshift    <= wd_aligned << 8;
            end else begin
              mem_re <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        XFER: begin
          if (beat == last) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (lat_we) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            beat     <= beat + 2'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (lat_we) begin
              mem_wdata <= wshift[31:24];
              wshift    <= wshift << 8;
            end
          end
        end

        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          rdata <= rext;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-wide memory, transaction-level expected timeline,
// per-cycle compare process and directed literal checks.
module tb_dmem_ctrl;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        reset, req, we, sign_ext;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy, done, err, mem_we, mem_re;
  logic [7:0]  mem_addr, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // Byte memory seen by the DUT, plus the model's own copy.
  logic [7:0] mem [256];
  logic [7:0] mmem [256];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number.
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_err  [MAXC];
  bit          e_we   [MAXC];
  bit          e_re   [MAXC];
  bit          e_rchk [MAXC];
  logic [7:0]  e_addr [MAXC];
  logic [7:0]  e_wd   [MAXC];
  logic [31:0] e_rdata[MAXC];
  logic [31:0] cur_rdata = 32'h0;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Model: a request in cycle t touches bytes in cycles t+1..t+n, loads finish
  // one cycle later than stores, and result bytes are big-endian.
  task automatic schedule(input int t, input bit w, input logic [1:0] sz, input bit sx,
                          input logic [7:0] a, input logic [31:0] wd, output int d);
    int n;
    logic [31:0] v, mask;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
      e_err[t+1]   = 1'b1;
      e_rchk[t+1]  = 1'b1;
      e_rdata[t+1] = cur_rdata;
      d = 1;
      return;
    end
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v    = 32'h0;
    for (int k = 0; k < n; k++) begin
      e_addr[t+1+k] = a + 8'(k);
      if (w) begin
        e_we[t+1+k] = 1'b1;
        e_wd[t+1+k] = 8'((wd & mask) >> (8 * (n - 1 - k)));
      end else begin
        e_re[t+1+k] = 1'b1;
        v = (v << 8) | 32'(mmem[a + 8'(k)]);
      end
    end
    d = w ? n + 1 : n + 2;
    for (int c = t + 1; c < t + d; c++) e_busy[c] = 1'b1;
    e_done[t+d] = 1'b1;
    if (!w) begin
      if (sx && v[8*n-1]) v = v | ~mask;
      cur_rdata    = v;
      e_rchk[t+d]  = 1'b1;
      e_rdata[t+d] = v;
    end
  endtask

  // Reset sampled at the end of cycle r discards everything scheduled after it.
  task automatic abort(input int r);
    for (int c = r + 1; c < MAXC; c++) begin
      e_busy[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0;
      e_we[c] = 1'b0; e_re[c] = 1'b0; e_rchk[c] = 1'b0;
    end
    cur_rdata    = 32'h0;
    e_rchk[r+1]  = 1'b1;
    e_rdata[r+1] = 32'h0;
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      chk("busy",   32'(busy),   32'(e_busy[cyc]));
      chk("done",   32'(done),   32'(e_done[cyc]));
      chk("err",    32'(err),    32'(e_err[cyc]));
      chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
      chk("mem_re", 32'(mem_re), 32'(e_re[cyc]));
      if (e_we[cyc] || e_re[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
      if (e_we[cyc]) begin
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
        mmem[e_addr[cyc]] = e_wd[cyc];
      end
      if (e_rchk[cyc]) chk("rdata", rdata, e_rdata[cyc]);
    end
  end

  // Called at a negedge; returns at the negedge of the first idle cycle after completion.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [7:0] a, input logic [31:0] wd, output int d);
    int t;
    t = cyc;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    schedule(t, w, sz, sx, a, wd, d);
    @(negedge clk);
    req = 1'b0;
    repeat (d) @(negedge clk);
  endtask

  int d, d2, t, nbad;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      mmem[i] = 8'h00;
    end
    mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
    mmem[8'h10] = 8'hDE; mmem[8'h11] = 8'hAD; mmem[8'h12] = 8'hBE; mmem[8'h13] = 8'hEF;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 8'h00; wdata = 32'h0;

    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Loads from DE AD BE EF at 0x10.
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, d);
    chk("lw_lat", d, 6);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 1'b1, 8'h11, 32'h0, d);
    chk("lb_lat", d, 3);
    chk("lb_rdata", rdata, 32'hFFFF_FFAD);
    do_req(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, d);
    chk("lbu_rdata", rdata, 32'h0000_00AD);
    do_req(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, d);
    chk("lh_rdata", rdata, 32'hFFFF_BEEF);
    do_req(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, d);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);

    // Stores and read-back.
    do_req(1'b1, 2'b10, 1'b0, 8'h20, 32'h1234_5678, d);
    chk("sw_lat", d, 5);
    chk("sw_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, d);
    chk("lw20_rdata", rdata, 32'h1234_5678);
    do_req(1'b0, 2'b01, 1'b1, 8'h20, 32'h0, d);
    chk("lh20_rdata", rdata, 32'h0000_1234);
    do_req(1'b1, 2'b00, 1'b0, 8'h27, 32'h5A5A_5AA5, d);
    chk("sb_mem27", 32'(mem[8'h27]), 32'h0000_00A5);
    chk("sb_mem24", {8'h00, mem[8'h24], mem[8'h25], mem[8'h26]}, 32'h0);

    // Misaligned and illegal requests.
    do_req(1'b1, 2'b01, 1'b0, 8'h21, 32'hFFFF_FFFF, d);
    chk("sh_err_lat", d, 1);
    chk("sh_err_mem", 32'(mem[8'h21]), 32'h0000_0034);
    do_req(1'b0, 2'b10, 1'b0, 8'h22, 32'h0, d);
    do_req(1'b0, 2'b11, 1'b0, 8'h10, 32'h0, d);
    chk("err_rdata_held", rdata, 32'h0000_1234);

    // lw with req held high; ignored store while busy, then sw accepted from DONE.
    t = cyc;
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 8'h10; wdata = 32'h0;
    schedule(t, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, d);
    @(negedge clk);
    we = 1'b1; addr = 8'h50; wdata = 32'h1111_1111;
    repeat (d - 1) @(negedge clk);
    chk("b2b_done", 32'(done), 32'h1);
    addr = 8'h30; wdata = 32'hCAFE_F00D;
    schedule(cyc, 1'b1, 2'b10, 1'b0, 8'h30, 32'hCAFE_F00D, d2);
    @(negedge clk);
    req = 1'b0;
    repeat (d2) @(negedge clk);
    chk("b2b_mem30", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hCAFE_F00D);
    chk("b2b_mem50", {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]}, 32'h0);
    chk("b2b_rdata", rdata, 32'hDEAD_BEEF);

    // Reset during beat 1 of sw 0x40.
    t = cyc;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 8'h40; wdata = 32'hAABB_CCDD;
    schedule(t, 1'b1, 2'b10, 1'b0, 8'h40, 32'hAABB_CCDD, d);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    abort(cyc);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mid_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mid_state", 32'(fsm_state), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hAABB_0000);
    do_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, d);
    chk("rst_mid_lw", rdata, 32'hAABB_0000);

    repeat (2) @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) nbad++;
    chk("mem_image", nbad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
